// File: rtl/eq_pkg.sv
// Shared types and constants for the three-band EQ coefficient controller.
package eq_pkg;

  localparam int unsigned NUM_BANDS = 3;
  localparam int unsigned NUM_SLOTS = 5;
  localparam int unsigned NUM_COEFS = 15;
  localparam int unsigned COEF_W    = 16;
  localparam int unsigned ADDR_W    = 4;

  localparam logic [COEF_W-1:0] UNITY_B0 = 16'h4000;

  localparam int unsigned SLOT_B0 = 0;
  localparam int unsigned SLOT_B1 = 1;
  localparam int unsigned SLOT_B2 = 2;
  localparam int unsigned SLOT_A1 = 3;
  localparam int unsigned SLOT_A2 = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StSwap  = 2'd2
  } eq_state_e;

  typedef logic [NUM_COEFS-1:0][COEF_W-1:0] coef_bank_t;

  // Unity passthrough for every band: b0 = 1.0 in Q2.14, everything else zero.
  function automatic coef_bank_t unity_bank();
    coef_bank_t b;
    b = '0;
    b[SLOT_B0]               = UNITY_B0;
    b[NUM_SLOTS + SLOT_B0]   = UNITY_B0;
    b[2*NUM_SLOTS + SLOT_B0] = UNITY_B0;
    return b;
  endfunction

endpackage

// File: rtl/eq_coef_ctrl_if.sv
// Host/engine-facing bundle of the EQ coefficient controller.
// Readback signals exist only when EQ_COEF_READBACK_EN is defined.
interface eq_coef_ctrl_if;
  import eq_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [COEF_W-1:0] wr_data;
  logic              commit_req;
  logic              sample_edge;
  logic              engine_busy;
  coef_bank_t        coef_active;
  logic              armed;
  logic              commit_ack;
  logic              commit_abort;
  logic              wr_err;
`ifdef EQ_COEF_READBACK_EN
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bank;
  logic [COEF_W-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, commit_req, sample_edge, engine_busy, rd_addr, rd_bank,
    input  coef_active, armed, commit_ack, commit_abort, wr_err, rd_data
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, commit_req, sample_edge, engine_busy, rd_addr, rd_bank,
    output coef_active, armed, commit_ack, commit_abort, wr_err, rd_data
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, commit_req, sample_edge, engine_busy,
    input  coef_active, armed, commit_ack, commit_abort, wr_err
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, commit_req, sample_edge, engine_busy,
    output coef_active, armed, commit_ack, commit_abort, wr_err
  );
`endif

endinterface

// File: rtl/eq_coef_regfile.sv
// Shadow and active coefficient banks; swap copies the whole shadow bank in one edge.
// Optional registered readback under EQ_COEF_READBACK_EN.
module eq_coef_regfile
  import eq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [COEF_W-1:0] wr_data_i,
  input  logic              swap_i,
  output coef_bank_t        active_o
`ifdef EQ_COEF_READBACK_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_bank_i,
  output logic [COEF_W-1:0] rd_data_o
`endif
);

  coef_bank_t shadow_q, shadow_d;
  coef_bank_t active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en_i) begin
      shadow_d[wr_addr_i] = wr_data_i;
    end
    if (swap_i) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q <= unity_bank();
      active_q <= unity_bank();
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

`ifdef EQ_COEF_READBACK_EN
  logic [COEF_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = '0;
    if (rd_addr_i < ADDR_W'(NUM_COEFS)) begin
      rd_data_d = rd_bank_i ? active_q[rd_addr_i] : shadow_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
`endif

endmodule

// File: rtl/eq_coef_ctrl.sv
// Commit controller: shadow writes in idle, arms on commit_req, swaps on the first idle
// sample edge or aborts after TIMEOUT_EDGES busy edges. Readback via EQ_COEF_READBACK_EN.
module eq_coef_ctrl
  import eq_pkg::*;
#(
  parameter int unsigned TIMEOUT_EDGES = 8
) (
  input logic           clk,
  input logic           reset,
  eq_coef_ctrl_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(TIMEOUT_EDGES + 1);
  localparam logic [CntW-1:0] LastSkip   = CntW'(TIMEOUT_EDGES - 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT_EDGES);

  eq_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            abort_q, abort_d;
  logic            wr_err_q, wr_err_d;
  logic            swap;
  logic            wr_ok;

  // Shadow is locked for the whole commit window, not just the swap cycle.
  assign wr_ok    = bus_io.wr_en && (state_q == StIdle) && (bus_io.wr_addr < ADDR_W'(NUM_COEFS));
  assign wr_err_d = bus_io.wr_en && !wr_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    swap    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.commit_req) begin
          state_d = StArmed;
          cnt_d   = '0;
        end
      end
      StArmed: begin
        if (bus_io.sample_edge) begin
          if (!bus_io.engine_busy) begin
            state_d = StSwap;
            swap    = 1'b1;
          end else if (cnt_q >= LastSkip) begin
            state_d = StIdle;
            abort_d = 1'b1;
            cnt_d   = TimeoutCnt;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StSwap: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign bus_io.armed        = (state_q == StArmed);
  assign bus_io.commit_ack   = (state_q == StSwap);
  assign bus_io.commit_abort = abort_q;
  assign bus_io.wr_err       = wr_err_q;

  // Active bank loads on the qualifying edge so it is already new while commit_ack is high.
  eq_coef_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_ok),
    .wr_addr_i (bus_io.wr_addr),
    .wr_data_i (bus_io.wr_data),
    .swap_i    (swap),
    .active_o  (bus_io.coef_active)
`ifdef EQ_COEF_READBACK_EN
    ,
    .rd_addr_i (bus_io.rd_addr),
    .rd_bank_i (bus_io.rd_bank),
    .rd_data_o (bus_io.rd_data)
`endif
  );

endmodule

// File: tb/tb_eq_coef_ctrl.sv
// Directed bench for eq_coef_ctrl: cycle model plus hand-computed spot checks.
module tb_eq_coef_ctrl;
  import eq_pkg::*;

  localparam int unsigned T = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  eq_coef_ctrl_if bus ();

  eq_coef_ctrl #(.TIMEOUT_EDGES(T)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model state: what the outputs must be after the most recent rising edge.
  logic [15:0] m_shadow [15];
  logic [15:0] m_active [15];
  bit          m_pending, m_swap, m_abort, m_err;
  int          m_skips;
`ifdef EQ_COEF_READBACK_EN
  logic [15:0] m_rd;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit err, abort;
    if (!reset) begin
      for (int i = 0; i < 15; i++) begin
        m_shadow[i] = (i % 5 == 0) ? 16'h4000 : 16'h0000;
        m_active[i] = m_shadow[i];
      end
      m_pending = 0; m_swap = 0; m_abort = 0; m_err = 0; m_skips = 0;
`ifdef EQ_COEF_READBACK_EN
      m_rd = 16'h0000;
`endif
      return;
    end
`ifdef EQ_COEF_READBACK_EN
    m_rd = (bus.rd_addr == 4'd15) ? 16'h0000 :
           (bus.rd_bank ? m_active[bus.rd_addr] : m_shadow[bus.rd_addr]);
`endif
    err   = bus.wr_en && (bus.wr_addr == 4'd15 || m_pending || m_swap);
    abort = 0;
    if (m_swap) begin
      m_swap = 0;
    end else if (m_pending) begin
      if (bus.sample_edge) begin
        if (!bus.engine_busy) begin
          for (int i = 0; i < 15; i++) m_active[i] = m_shadow[i];
          m_pending = 0;
          m_swap    = 1;
        end else begin
          m_skips++;
          if (m_skips >= T) begin
            m_pending = 0;
            abort     = 1;
          end
        end
      end
    end else begin
      if (bus.wr_en && bus.wr_addr != 4'd15) m_shadow[bus.wr_addr] = bus.wr_data;
      if (bus.commit_req) begin
        m_pending = 1;
        m_skips   = 0;
      end
    end
    m_err   = err;
    m_abort = abort;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("armed", 32'(bus.armed), 32'(m_pending));
      check("commit_ack", 32'(bus.commit_ack), 32'(m_swap));
      check("commit_abort", 32'(bus.commit_abort), 32'(m_abort));
      check("wr_err", 32'(bus.wr_err), 32'(m_err));
      for (int i = 0; i < 15; i++) begin
        check($sformatf("coef_active[%0d]", i), 32'(bus.coef_active[i]), 32'(m_active[i]));
      end
`ifdef EQ_COEF_READBACK_EN
      check("rd_data", 32'(bus.rd_data), 32'(m_rd));
`endif
    end
  end

  task automatic cyc(input bit we, input logic [3:0] a, input logic [15:0] d,
                     input bit cr, input bit se, input bit bz);
    bus.wr_en       = we;
    bus.wr_addr     = a;
    bus.wr_data     = d;
    bus.commit_req  = cr;
    bus.sample_edge = se;
    bus.engine_busy = bz;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cyc(0, 4'd0, 16'h0, 0, 0, 0);
  endtask

  task automatic busy_edge();
    cyc(0, 4'd0, 16'h0, 0, 1, 1);
  endtask

  task automatic good_edge();
    cyc(0, 4'd0, 16'h0, 0, 1, 0);
  endtask

  initial begin
`ifdef EQ_COEF_READBACK_EN
    bus.rd_addr = 4'd2;
    bus.rd_bank = 1'b0;
`endif
    reset = 1'b0;
    idle();
    idle();
    reset = 1'b1;
    chk_en = 1'b1;
    check("reset active[0]", 32'(bus.coef_active[0]), 32'h4000);
    check("reset active[5]", 32'(bus.coef_active[5]), 32'h4000);
    check("reset active[10]", 32'(bus.coef_active[10]), 32'h4000);
    check("reset active[1]", 32'(bus.coef_active[1]), 32'h0000);
    check("reset armed", 32'(bus.armed), 32'h0);
    idle();

    // Basic commit: shadow write invisible until the swap.
    cyc(1, 4'd5, 16'h1234, 0, 0, 0);
    check("pre-commit active[5]", 32'(bus.coef_active[5]), 32'h4000);
    cyc(0, 4'd0, 16'h0, 1, 0, 0);
    check("armed after commit_req", 32'(bus.armed), 32'h1);
    cyc(0, 4'd0, 16'h0, 0, 0, 1);  // busy without an edge does nothing
    good_edge();
    check("ack one cycle after edge", 32'(bus.commit_ack), 32'h1);
    check("active[5] new", 32'(bus.coef_active[5]), 32'h1234);
    idle();
    check("ack is a pulse", 32'(bus.commit_ack), 32'h0);

    // Write + commit in one cycle, three skipped edges, then the swap.
    cyc(1, 4'd7, 16'hC000, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      busy_edge();
      check("active[7] held while skipping", 32'(bus.coef_active[7]), 32'h0000);
    end
    good_edge();
    check("ack after 4th edge", 32'(bus.commit_ack), 32'h1);
    check("active[7] committed", 32'(bus.coef_active[7]), 32'hC000);
    idle();

    // Timeout: commit_req and a write while armed must not disturb the count.
    cyc(1, 4'd2, 16'h1111, 1, 0, 0);
    for (int k = 0; k < 4; k++) busy_edge();
    cyc(0, 4'd0, 16'h0, 1, 0, 0);
    cyc(1, 4'd3, 16'h2222, 0, 0, 0);
    check("wr_err while armed", 32'(bus.wr_err), 32'h1);
    for (int k = 0; k < 3; k++) busy_edge();
    check("no abort after 7 edges", 32'(bus.commit_abort), 32'h0);
    busy_edge();
    check("abort on 8th edge", 32'(bus.commit_abort), 32'h1);
    check("idle after abort", 32'(bus.armed), 32'h0);
    check("active[2] unchanged on abort", 32'(bus.coef_active[2]), 32'h0000);
    good_edge();  // stray edge in idle must not swap
    check("abort is a pulse", 32'(bus.commit_abort), 32'h0);

    // Address 15 rejected; then commit to show shadow kept 0x1111 but not 0x2222.
    cyc(1, 4'd15, 16'hFFFF, 0, 0, 0);
    check("wr_err on addr 15", 32'(bus.wr_err), 32'h1);
    cyc(0, 4'd0, 16'h0, 1, 0, 0);
    good_edge();
    check("shadow retained after abort", 32'(bus.coef_active[2]), 32'h1111);
    check("armed write rejected", 32'(bus.coef_active[3]), 32'h0000);
    idle();

    // Reset in the middle of a commit abandons it and restores unity.
    cyc(1, 4'd0, 16'h7FFF, 0, 0, 0);
    cyc(0, 4'd0, 16'h0, 1, 0, 0);
    busy_edge();
    reset = 1'b0;
    idle();
    reset = 1'b1;
    check("armed cleared by reset", 32'(bus.armed), 32'h0);
    check("active[5] unity after reset", 32'(bus.coef_active[5]), 32'h4000);
    check("active[7] unity after reset", 32'(bus.coef_active[7]), 32'h0000);
    good_edge();
    check("no ack after reset", 32'(bus.commit_ack), 32'h0);
    cyc(0, 4'd0, 16'h0, 1, 0, 0);
    good_edge();
    check("shadow unity after reset", 32'(bus.coef_active[0]), 32'h4000);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
